// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Moore controller for a two-road intersection (main street and side street).
// Every phase is timed by an external 6-bit loadable up-counter: this block
// strobes load_o (value_o is always zero) on every state change, so count_i
// reads 0 in the first cycle of each phase and a phase of length T ends on
// the cycle where count_i == T-1.
// A side-street demand sensor ends main green once its minimum has elapsed.
// An emergency request forces the intersection into an all-red hold.
module traffic_phase_ctrl #(
  parameter int T_MG = 30,
  parameter int T_MY = 4,
  parameter int T_AR = 2,
  parameter int T_SG = 20,
  parameter int T_SY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] count_i,
  input  logic       sensor_i,
  input  logic       emerg_i,
  output logic       load_o,
  output logic [5:0] value_o,
  output logic [2:0] main_o,
  output logic [2:0] side_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5,
    EM  = 3'd6
  } state_t;

  // Last count value of each timed phase; equality compares only, the
  // counter is reloaded on every phase change so it never skips past them.
  localparam logic [5:0] MG_END = 6'(T_MG - 1);
  localparam logic [5:0] MY_END = 6'(T_MY - 1);
  localparam logic [5:0] AR_END = 6'(T_AR - 1);
  localparam logic [5:0] SG_END = 6'(T_SG - 1);
  localparam logic [5:0] SY_END = 6'(T_SY - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t state;
  state_t next_state;
  logic   min_flag;
  logic   mg_min_done;

  function automatic logic [2:0] main_lamp(input state_t s);
    case (s)
      MG:      main_lamp = GRN;
      MY:      main_lamp = YEL;
      default: main_lamp = RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input state_t s);
    case (s)
      SG:      side_lamp = GRN;
      SY:      side_lamp = YEL;
      default: side_lamp = RED;
    endcase
  endfunction

  // Main green may run past 63 cycles and the counter then wraps, so the
  // minimum-green expiry is remembered in a sticky flag as well as decoded live.
  assign mg_min_done = min_flag || (count_i == MG_END);

  // Next-state decision, with emergency handling taking priority over timing.
  always_comb begin
    next_state = state;
    case (state)
      MG: begin
        if (emerg_i || (mg_min_done && sensor_i)) next_state = MY;
      end
      MY: begin
        if (count_i == MY_END) next_state = AR1;
      end
      AR1: begin
        if (emerg_i)                next_state = EM;
        else if (count_i == AR_END) next_state = SG;
      end
      SG: begin
        if (emerg_i || (count_i == SG_END)) next_state = SY;
      end
      SY: begin
        if (count_i == SY_END) next_state = AR2;
      end
      AR2: begin
        if (emerg_i)                next_state = EM;
        else if (count_i == AR_END) next_state = MG;
      end
      EM: begin
        if (!emerg_i) next_state = AR2;
      end
      default: next_state = AR2;
    endcase
  end

  // State register, min-green flag and registered lamp drivers; lamps are
  // loaded from the state being entered so they always match the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= AR2;
      min_flag <= 1'b0;
      main_o   <= RED;
      side_o   <= RED;
    end else begin
      state  <= next_state;
      main_o <= main_lamp(next_state);
      side_o <= side_lamp(next_state);
      if ((state == MG) && (next_state == MG)) min_flag <= mg_min_done;
      else                                      min_flag <= 1'b0;
    end
  end

  assign load_o  = !rst || (next_state != state);
  assign value_o = 6'd0;
  assign state_o = state;

endmodule
